// File: rtl/mux_n_1_seq.sv
// mux_n_1_seq: parametrised registered N-to-1 multiplexer with a valid/ready
// output stage and an optional auto-scan sequencer that walks every channel.
// Optional feature macro: MUX_SCAN_EN builds the SCAN/DONE sequencer. Without
// it only direct mode exists, and busy/done are tied low.
module mux_n_1_seq #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]      s,
    input  logic                  in_valid,
    input  logic                  mode,
    input  logic                  start,
    output logic [WIDTH-1:0]      o,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    // The channel count is held one bit wider than the select so that
    // N_CH == 2**SEL_W is still representable.
    localparam logic [SEL_W:0] LP_NCH = (SEL_W+1)'(N_CH);

    logic             w_ldOk;
    logic             w_accept;
    logic             w_dirErr;
    logic [WIDTH-1:0] w_dirData;

    assign w_ldOk   = !o_valid || o_ready;
    assign w_accept = o_valid && o_ready;
    assign w_dirErr = ({1'b0, s} >= LP_NCH);

    // Direct-mode data: the channel addressed by s, or zero when s points past the last channel
    always_comb begin
        w_dirData = '0;
        for (int k = 0; k < N_CH; k++) begin
            if ({1'b0, s} == (SEL_W+1)'(k)) begin
                w_dirData = i[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_SCAN_EN

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           r_state;
    logic [SEL_W:0]   r_cnt;
    logic [WIDTH-1:0] w_cntData;

    // Scan-mode data: the channel addressed by the scan counter, sampled live at load time
    always_comb begin
        w_cntData = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_cnt == (SEL_W+1)'(k)) begin
                w_cntData = i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Sequencer FSM and output register. A handshake clears o_valid, and a load in the same cycle overrides that, so there is no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            o       <= '0;
            o_sel   <= '0;
            o_valid <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                o_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (mode) begin
                        if (start && w_ldOk) begin
                            o       <= i[WIDTH-1:0];
                            o_sel   <= '0;
                            err     <= 1'b0;
                            o_valid <= 1'b1;
                            r_cnt   <= (SEL_W+1)'(1);
                            r_state <= SCAN;
                            busy    <= 1'b1;
                        end
                    end else if (in_valid && w_ldOk) begin
                        o       <= w_dirData;
                        o_sel   <= s;
                        err     <= w_dirErr;
                        o_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (r_cnt == LP_NCH) begin
                        // The last channel is on the output; finish once it has been taken
                        if (w_accept) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end
                    end else if (w_ldOk) begin
                        o       <= w_cntData;
                        o_sel   <= r_cnt[SEL_W-1:0];
                        err     <= 1'b0;
                        o_valid <= 1'b1;
                        r_cnt   <= r_cnt + (SEL_W+1)'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`else

    // mode and start have no meaning without the sequencer
    logic w_unusedScan;
    assign w_unusedScan = &{1'b0, mode, start};

    // Direct-only output register. A handshake clears o_valid, and a load in the same cycle overrides that
    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_sel   <= '0;
            o_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (w_accept) begin
                o_valid <= 1'b0;
            end
            if (in_valid && w_ldOk) begin
                o       <= w_dirData;
                o_sel   <= s;
                err     <= w_dirErr;
                o_valid <= 1'b1;
            end
        end
    end

    assign busy = 1'b0;
    assign done = 1'b0;

`endif

endmodule

// File: tb/tb_mux_n_1_seq.sv
// tb_mux_n_1_seq: self-checking bench for mux_n_1_seq. Expected words are
// queued when a load is requested and compared whenever the DUT hands a word
// to the consumer.
module tb_mux_n_1_seq;

    localparam int N_CH  = 6;
    localparam int WIDTH = 4;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
        logic             err;
    } word_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] i;
    logic [SEL_W-1:0]      s;
    logic                  in_valid;
    logic                  mode;
    logic                  start;
    logic [WIDTH-1:0]      o;
    logic [SEL_W-1:0]      o_sel;
    logic                  o_valid;
    logic                  o_ready;
    logic                  err;
    logic                  busy;
    logic                  done;

    word_t            expQ[$];
    word_t            monExp;
    logic [WIDTH-1:0] chVal[N_CH];
    int               checks = 0;
    int               errors = 0;

    mux_n_1_seq #(
        .N_CH (N_CH),
        .WIDTH(WIDTH),
        .SEL_W(SEL_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .s       (s),
        .in_valid(in_valid),
        .mode    (mode),
        .start   (start),
        .o       (o),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .err     (err),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; outputs are read then or at the falling edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Fresh channel values, all distinct so a wrong-channel pick is visible
    task automatic setChannels();
        logic [WIDTH-1:0] base;
        base = WIDTH'($urandom);
        for (int k = 0; k < N_CH; k++) begin
            chVal[k] = base + WIDTH'(k * 3);
            i[k*WIDTH +: WIDTH] = chVal[k];
        end
    endtask

    task automatic pushWord(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data, input logic e);
        word_t w;
        w.sel  = sel;
        w.data = data;
        w.err  = e;
        expQ.push_back(w);
    endtask

    // Scoreboard: every word taken by the consumer must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_unexpected got sel=%0d o=%h err=%b, no word expected", o_sel, o, err);
            end else begin
                monExp = expQ.pop_front();
                if (o_sel !== monExp.sel || o !== monExp.data || err !== monExp.err) begin
                    errors++;
                    $display("[TB] FAIL scoreboard got sel=%0d o=%h err=%b want sel=%0d o=%h err=%b",
                             o_sel, o, err, monExp.sel, monExp.data, monExp.err);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; start = 1'b0; o_ready = 1'b0;
        s = '0; i = '0;
        cyc(); cyc();
        checks++;
        if ({o, o_sel, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got o=%h sel=%0d err=%b want all 0", o, o_sel, err);
        end
        checks++;
        if ({o_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got valid/busy/done=%b want 000", {o_valid, busy, done});
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got valid=%b busy=%b want 0 0", o_valid, busy);
        end
    endtask

    task automatic test_direct_sweep();
        setChannels();
        o_ready = 1'b1; mode = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            s = SEL_W'(k);
            pushWord(SEL_W'(k), chVal[k], 1'b0);
            cyc();
            checks++;
            if (o_valid !== 1'b1 || o_sel !== SEL_W'(k) || o !== chVal[k]) begin
                errors++;
                $display("[TB] FAIL direct_sweep k=%0d got valid=%b sel=%0d o=%h want 1 %0d %h",
                         k, o_valid, o_sel, o, k, chVal[k]);
            end
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL direct_drain got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        setChannels();
        o_ready = 1'b0; mode = 1'b0; in_valid = 1'b1; s = 3'd3;
        held = chVal[3];
        pushWord(3'd3, held, 1'b0);
        cyc();
        for (int n = 0; n < 5; n++) begin
            s = SEL_W'($urandom_range(0, 7));
            setChannels();
            cyc();
            checks++;
            if (o_valid !== 1'b1 || o_sel !== 3'd3 || o !== held || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold n=%0d got valid=%b sel=%0d o=%h want 1 3 %h",
                         n, o_valid, o_sel, o, held);
            end
        end
        o_ready = 1'b1; s = 3'd1;
        pushWord(3'd1, chVal[1], 1'b0);
        cyc();
        checks++;
        if (o_valid !== 1'b1 || o_sel !== 3'd1 || o !== chVal[1]) begin
            errors++;
            $display("[TB] FAIL backpressure_release got valid=%b sel=%0d o=%h want 1 1 %h",
                     o_valid, o_sel, o, chVal[1]);
        end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_out_of_range();
        setChannels();
        o_ready = 1'b1; mode = 1'b0; in_valid = 1'b1;
        s = 3'd7;
        pushWord(3'd7, '0, 1'b1);
        cyc();
        checks++;
        if (err !== 1'b1 || o !== '0 || o_sel !== 3'd7) begin
            errors++;
            $display("[TB] FAIL range_s7 got err=%b o=%h sel=%0d want 1 0 7", err, o, o_sel);
        end
        s = 3'd6;
        pushWord(3'd6, '0, 1'b1);
        cyc();
        checks++;
        if (err !== 1'b1 || o !== '0) begin
            errors++;
            $display("[TB] FAIL range_s6 got err=%b o=%h want 1 0", err, o);
        end
        s = 3'd2;
        pushWord(3'd2, chVal[2], 1'b0);
        cyc();
        checks++;
        if (err !== 1'b0 || o !== chVal[2]) begin
            errors++;
            $display("[TB] FAIL range_clear got err=%b o=%h want 0 %h", err, o, chVal[2]);
        end
        s = 3'd5;
        pushWord(3'd5, chVal[5], 1'b0);
        cyc();
        checks++;
        if (err !== 1'b0 || o !== chVal[5]) begin
            errors++;
            $display("[TB] FAIL range_last got err=%b o=%h want 0 %h", err, o, chVal[5]);
        end
        in_valid = 1'b0;
        cyc();
    endtask

`ifdef MUX_SCAN_EN

    task automatic test_start_blocked();
        setChannels();
        o_ready = 1'b0; mode = 1'b0; in_valid = 1'b1; s = 3'd2;
        pushWord(3'd2, chVal[2], 1'b0);
        cyc();
        in_valid = 1'b0; mode = 1'b1; start = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || o_sel !== 3'd2 || o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_blocked got busy=%b sel=%0d valid=%b want 0 2 1", busy, o_sel, o_valid);
        end
        start = 1'b0; o_ready = 1'b1;
        cyc();
        in_valid = 1'b1; s = 3'd4;
        cyc();
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode1_in_valid got valid=%b busy=%b want 0 0", o_valid, busy);
        end
        in_valid = 1'b0; mode = 1'b0;
    endtask

    task automatic test_full_scan();
        setChannels();
        o_ready = 1'b1; mode = 1'b1; in_valid = 1'b0;
        pushWord('0, chVal[0], 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (o_sel !== '0 || o !== chVal[0] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL scan_first got sel=%0d o=%h busy=%b done=%b want 0 %h 1 0",
                     o_sel, o, busy, done, chVal[0]);
        end
        for (int k = 1; k < N_CH; k++) begin
            setChannels();
            pushWord(SEL_W'(k), chVal[k], 1'b0);
            cyc();
            checks++;
            if (o_sel !== SEL_W'(k) || o !== chVal[k] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL scan_step k=%0d got sel=%0d o=%h busy=%b done=%b want %0d %h 1 0",
                         k, o_sel, o, busy, done, k, chVal[k]);
            end
        end
        cyc();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL scan_done got done=%b busy=%b valid=%b want 1 1 0", done, busy, o_valid);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL scan_idle got done=%b busy=%b want 0 0", done, busy);
        end
        mode = 1'b0;
    endtask

    task automatic test_scan_stall();
        setChannels();
        o_ready = 1'b1; mode = 1'b1; in_valid = 1'b0;
        pushWord('0, chVal[0], 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k < N_CH; k++) begin
            setChannels();
            pushWord(SEL_W'(k), chVal[k], 1'b0);
            cyc();
            checks++;
            if (o_sel !== SEL_W'(k) || o !== chVal[k]) begin
                errors++;
                $display("[TB] FAIL stall_step k=%0d got sel=%0d o=%h want %0d %h", k, o_sel, o, k, chVal[k]);
            end
            if (k == 4) begin
                o_ready = 1'b0; start = 1'b1;
                for (int n = 0; n < 3; n++) begin
                    cyc();
                    checks++;
                    if (o_sel !== 3'd4 || o !== chVal[4] || o_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL stall_hold n=%0d got sel=%0d o=%h valid=%b busy=%b done=%b want 4 %h 1 1 0",
                                 n, o_sel, o, o_valid, busy, done, chVal[4]);
                    end
                end
                o_ready = 1'b1; start = 1'b0;
            end
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_done got done=%b want 1", done);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_idle got done=%b busy=%b want 0 0", done, busy);
        end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        setChannels();
        o_ready = 1'b1; mode = 1'b1; in_valid = 1'b0;
        pushWord('0, chVal[0], 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            setChannels();
            pushWord(SEL_W'(k), chVal[k], 1'b0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        checks++;
        if ({o, o_sel, o_valid, err, busy, done} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_scan_reset got o=%h sel=%0d valid=%b err=%b busy=%b done=%b want all 0",
                     o, o_sel, o_valid, err, busy, done);
        end
        expQ.delete();
        rst = 1'b0;
        setChannels();
        pushWord('0, chVal[0], 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (o_sel !== '0 || o !== chVal[0] || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart got sel=%0d o=%h busy=%b want 0 %h 1", o_sel, o, busy, chVal[0]);
        end
        for (int k = 1; k < N_CH; k++) begin
            setChannels();
            pushWord(SEL_W'(k), chVal[k], 1'b0);
            cyc();
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_done got done=%b want 1", done);
        end
        cyc();
        mode = 1'b0;
    endtask

`else

    task automatic test_mode_ignored();
        setChannels();
        o_ready = 1'b1; mode = 1'b1; start = 1'b1; in_valid = 1'b1; s = 3'd4;
        pushWord(3'd4, chVal[4], 1'b0);
        cyc();
        checks++;
        if (o_valid !== 1'b1 || o_sel !== 3'd4 || o !== chVal[4] || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode_ignored got valid=%b sel=%0d o=%h busy=%b done=%b want 1 4 %h 0 0",
                     o_valid, o_sel, o, busy, done, chVal[4]);
        end
        in_valid = 1'b0; start = 1'b0; mode = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_scan_flags got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

`endif

    initial begin
        test_reset();
        test_direct_sweep();
        test_backpressure();
        test_out_of_range();
`ifdef MUX_SCAN_EN
        test_start_blocked();
        test_full_scan();
        test_scan_stall();
        test_reset_mid_scan();
`else
        test_mode_ignored();
`endif
        cyc();
        cyc();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got %0d words pending want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
